pipeline_stall_scheduler: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It arbitrates four hazard sources and drives every pipeline-register write enable and flush:
- data-memory wait states
- load-use hazard
- multi-cycle mult/div busy
- EX-resolved taken branch/jump

It owns the mult/div busy counter, the memory-wait state machine and stall statistics. It sits beside the datapath, with inputs from the ID/EX/MEM stages and outputs to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipeline_stall_scheduler.sv | 166 ++++++++++++++++
 tb/tb_pipeline_stall_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipeline_stall_scheduler                                                   |
// | Stall/flush sequencer for the 5-stage MIPS pipeline: memory wait, load-use,|
// | mult/div busy and taken-branch arbitration, plus stall statistics.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipeline_stall_scheduler #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16,
  parameter int IGNORE_R0   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             ID_EX_MemRead,
  input  logic             id_md_op,
  input  logic             id_uses_hilo,
  input  logic             ex_md_start,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [7:0] c_md_latency  = 8'(MD_LATENCY);
  localparam logic [7:0] c_mem_timeout = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic [7:0]       w_wait_nxt;
  logic [7:0]       r_md_cnt;
  logic             r_md_done;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_freeze;
  logic w_lu;
  logic w_mdh;
  logic w_md_load;

  assign w_freeze = mem_req & ~mem_ready;
  assign w_lu     = ID_EX_MemRead & ((Rs == ID_EX_Rt) | (Rt == ID_EX_Rt))
                  & ~((IGNORE_R0 != 0) & (ID_EX_Rt == 5'd0));
  assign w_mdh    = md_busy & (id_md_op | id_uses_hilo);

  // Enables are gated by reset so they drop the instant reset asserts.
  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    if (!reset) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
    end else if (w_freeze) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
    end else if (w_lu | w_mdh) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_flush  = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_freeze) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = 8'd0;
        end else if (r_wait_cnt < c_mem_timeout) begin
          w_wait_nxt  = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_wait_nxt == c_mem_timeout) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

  // A start stalled by a memory freeze is not accepted by the unit.
  assign w_md_load = ex_md_start & EX_MEM_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt  <= 8'd0;
      r_md_done <= 1'b0;
    end else begin
      if (w_md_load) begin
        r_md_cnt <= c_md_latency;
      end else if (r_md_cnt != 8'd0) begin
        r_md_cnt <= r_md_cnt - 8'd1;
      end
      r_md_done <= (r_md_cnt == 8'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (!PC_write && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign md_busy      = (r_md_cnt != 8'd0);
  assign md_done      = r_md_done;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipeline_stall_scheduler                                                |
// | Directed-vector bench for pipeline_stall_scheduler.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipeline_stall_scheduler;

  localparam int CNT_W = 3;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_flush}
  localparam logic [6:0] C_OFF    = 7'b0000000;
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_BRANCH = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs, Rt, ID_EX_Rt;
  logic ID_EX_MemRead, id_md_op, id_uses_hilo, ex_md_start, branch_taken, mem_req, mem_ready;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_flush;
  logic md_busy, md_done, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0] ctl;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_flush};

  pipeline_stall_scheduler #(
    .MD_LATENCY (4),
    .MEM_TIMEOUT(3),
    .CNT_W      (CNT_W),
    .IGNORE_R0  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rs           (Rs),
    .Rt           (Rt),
    .ID_EX_Rt     (ID_EX_Rt),
    .ID_EX_MemRead(ID_EX_MemRead),
    .id_md_op     (id_md_op),
    .id_uses_hilo (id_uses_hilo),
    .ex_md_start  (ex_md_start),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_write  (ID_EX_write),
    .ID_EX_flush  (ID_EX_flush),
    .EX_MEM_write (EX_MEM_write),
    .MEM_WB_flush (MEM_WB_flush),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_in();
    Rs = 5'd0; Rt = 5'd0; ID_EX_Rt = 5'd0;
    ID_EX_MemRead = 1'b0; id_md_op = 1'b0; id_uses_hilo = 1'b0;
    ex_md_start = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    reset = 1'b0;
    #2;
    check("rst_ctl", 32'(ctl), 32'(C_OFF));
    check("rst_busy", 32'(md_busy), 0);
    check("rst_tmo", 32'(mem_timeout), 0);
    check("rst_stall", 32'(stall_cycles), 0);

    @(negedge clk); reset = 1'b1; #1;
    check("idle", 32'(ctl), 32'(C_RUN));

    // Load-use on rs, then on rt, then a $0 match that must be ignored
    @(negedge clk); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; Rs = 5'd8; #1;
    check("lu_rs", 32'(ctl), 32'(C_STALL));
    @(negedge clk); Rs = 5'd3; Rt = 5'd8; #1;
    check("lu_rt", 32'(ctl), 32'(C_STALL));
    check("lu_cnt", 32'(stall_cycles), 1);
    @(negedge clk); ID_EX_Rt = 5'd0; Rs = 5'd0; Rt = 5'd0; #1;
    check("lu_r0", 32'(ctl), 32'(C_RUN));
    check("lu_cnt2", 32'(stall_cycles), 2);

    @(negedge clk); ID_EX_Rt = 5'd8; Rs = 5'd8; branch_taken = 1'b1; #1;
    check("br_lu", 32'(ctl), 32'(C_BRANCH));

    // Mult/div with mfhi following: stalled for 4 cycles, done on the 5th
    @(negedge clk); clear_in(); ex_md_start = 1'b1; #1;
    check("md_start", 32'(ctl), 32'(C_RUN));
    check("md_idle", 32'(md_busy), 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); clear_in(); id_uses_hilo = 1'b1; #1;
      check("md_stall", 32'(ctl), 32'(C_STALL));
      check("md_busy", 32'(md_busy), 1);
      check("md_nodone", 32'(md_done), 0);
    end
    @(negedge clk); #1;
    check("md_go", 32'(ctl), 32'(C_RUN));
    check("md_done", 32'(md_done), 1);
    check("md_free", 32'(md_busy), 0);
    check("md_cnt", 32'(stall_cycles), 6);
    @(negedge clk); clear_in(); #1;
    check("md_pulse", 32'(md_done), 0);

    // Start during freeze is dropped
    @(negedge clk); mem_req = 1'b1; ex_md_start = 1'b1; #1;
    check("fz_start", 32'(ctl), 32'(C_FREEZE));
    @(negedge clk); ex_md_start = 1'b0; mem_ready = 1'b1; #1;
    check("fz_ready", 32'(ctl), 32'(C_RUN));
    check("fz_nobusy", 32'(md_busy), 0);
    check("fz_cnt", 32'(stall_cycles), 7);
    @(negedge clk); clear_in(); ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd5; Rs = 5'd5; #1;
    check("sat_lu", 32'(ctl), 32'(C_STALL));
    @(negedge clk); clear_in(); ex_md_start = 1'b1; #1;
    check("sat_hold", 32'(stall_cycles), 7);
    @(negedge clk); clear_in(); id_md_op = 1'b1; #1;
    check("md_op", 32'(ctl), 32'(C_STALL));

    // Fresh start for the memory wait sequence
    @(negedge clk); clear_in(); reset = 1'b0; #1;
    check("rst2_ctl", 32'(ctl), 32'(C_OFF));
    @(negedge clk); reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) @(negedge clk);
      mem_req = 1'b1; mem_ready = 1'b0; #1;
      check("mw_ctl", 32'(ctl), 32'(C_FREEZE));
      check("mw_tmo", 32'(mem_timeout), (k >= 3) ? 1 : 0);
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    check("mw_done", 32'(ctl), 32'(C_RUN));
    check("mw_tmo_sticky", 32'(mem_timeout), 1);
    check("mw_cnt", 32'(stall_cycles), 5);
    @(negedge clk); clear_in(); #1;
    check("mw_tmo_hold", 32'(mem_timeout), 1);

    // Branch held during a 2-cycle freeze acts on the first unfrozen cycle
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1; #1;
      check("fb_frz", 32'(ctl), 32'(C_FREEZE));
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    check("fb_br", 32'(ctl), 32'(C_BRANCH));
    check("fb_cnt", 32'(stall_cycles), 7);
    @(negedge clk); branch_taken = 1'b0; mem_ready = 1'b0; #1;
    check("reenter", 32'(ctl), 32'(C_FREEZE));
    @(negedge clk); mem_ready = 1'b1; #1;
    check("reexit", 32'(ctl), 32'(C_RUN));
    check("sat_fz", 32'(stall_cycles), 7);

    // Async reset in the middle of a memory wait with mult/div busy
    @(negedge clk); clear_in(); ex_md_start = 1'b1; #1;
    @(negedge clk); clear_in(); mem_req = 1'b1; #1;
    @(negedge clk); #1;
    check("ar_busy", 32'(md_busy), 1);
    check("ar_frz", 32'(ctl), 32'(C_FREEZE));
    #2; reset = 1'b0; #1;
    check("ar_ctl", 32'(ctl), 32'(C_OFF));
    check("ar_busy0", 32'(md_busy), 0);
    check("ar_stall0", 32'(stall_cycles), 0);
    @(negedge clk); clear_in(); reset = 1'b1; #1;
    check("ar_run", 32'(ctl), 32'(C_RUN));
    check("ar_tmo", 32'(mem_timeout), 0);
    check("ar_md", 32'(md_busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_req = 1'b1; #1;
      if (k == 2) check("ar_wait2", 32'(mem_timeout), 0);
      if (k == 3) check("ar_wait3", 32'(mem_timeout), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
